// File: rtl/conv3x3_frame_sequencer.sv
// Streams one WIDTH x WIDTH frame from an FWFT FIFO into a conv3x3 engine as a zero-padded
// (WIDTH+2)^2 raster, then waits for WIDTH*WIDTH engine results. Option: CONV_SEQ_STALL_CNT_EN.
module conv3x3_frame_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WIDTH      = 7,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  eng_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      out_count
`ifdef CONV_SEQ_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_count
`endif
);

  localparam int unsigned     PosW    = $clog2(WIDTH + 2);
  localparam logic [PosW-1:0] LastPos = PosW'(WIDTH + 1);
  localparam logic [PosW-1:0] LastInt = PosW'(WIDTH);
  localparam logic [CNT_W-1:0] Total  = CNT_W'(WIDTH * WIDTH);

  typedef enum logic [1:0] {StIdle, StPadRow, StRow, StDrain} state_e;

  state_e          state_q;
  logic [PosW-1:0] row_q;
  logic [PosW-1:0] col_q;

  logic interior;
  logic at_pad;
  logic row_end;
  logic done_now;
  logic start_ok;

  // In StRow the row is always interior, so only the column decides padding.
  assign interior = (col_q != '0) && (col_q != LastPos);
  assign fifo_rd  = (state_q == StRow) && interior && !fifo_empty;
  assign at_pad   = (state_q == StPadRow) || ((state_q == StRow) && !interior);
  assign row_end  = (col_q == LastPos);
  assign busy     = (state_q != StIdle);
  assign done_now = (out_count == Total) || (eng_valid && (out_count == Total - 1'b1));
  // A start coinciding with the completion pulse belongs to the finished frame and is dropped.
  assign start_ok = (state_q == StIdle) && start && !frame_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_q      <= '0;
      pix_data   <= '0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_count  <= '0;
    end else begin
      frame_done <= 1'b0;
      pix_valid  <= 1'b0;
      if (busy && eng_valid && (out_count != Total)) begin
        out_count <= out_count + 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (start_ok) begin
            out_count <= '0;
            row_q     <= '0;
            col_q     <= '0;
            state_q   <= StPadRow;
          end
        end
        StPadRow, StRow: begin
          if (at_pad || fifo_rd) begin
            pix_valid <= 1'b1;
            pix_data  <= at_pad ? '0 : fifo_data;
            if (row_end) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
              if ((state_q == StPadRow) && (row_q == '0)) begin
                state_q <= StRow;
              end else if ((state_q == StRow) && (row_q == LastInt)) begin
                state_q <= StPadRow;
              end else if (state_q == StPadRow) begin
                row_q   <= '0;
                state_q <= StDrain;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (done_now) begin
            frame_done <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef CONV_SEQ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if ((state_q == StRow) && interior && fifo_empty && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule
